dekatron_seq: RTL and testbench

DEKATRON_SEQ -- requirements
Module: dekatron_seq

---
 rtl/dekatron_pkg.sv | 27 ++
 rtl/bcd2onehot.sv | 14 +
 rtl/dekatron_seq.sv | 165 ++++++++++++++++
 tb/tb_dekatron_seq.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/dekatron_pkg.sv
// Shared encodings for the dekatron counter sequencer: operations, FSM states,
// one-hot digit constants and a one-hot validity helper.
package dekatron_pkg;

    typedef enum logic [1:0] {
        OP_INC   = 2'b00,
        OP_DEC   = 2'b01,
        OP_LOAD  = 2'b10,
        OP_CLEAR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_STEP = 2'b01,
        ST_WAIT = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    localparam logic [9:0] ONEHOT_0 = 10'b00_0000_0001;
    localparam logic [9:0] ONEHOT_9 = 10'b10_0000_0000;

    // True when exactly one of the ten cathodes is glowing.
    function automatic logic is_onehot10(input logic [9:0] v);
        return (v != 10'd0) && ((v & (v - 10'd1)) == 10'd0);
    endfunction

endpackage

// File: rtl/bcd2onehot.sv
// Converts one BCD digit to the ten-cathode one-hot form; codes above 9 map to
// cathode 0 and raise o_invalid.
module bcd2onehot
    import dekatron_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [9:0] o_onehot,
    output logic       o_invalid
);

    assign o_invalid = (i_bcd > 4'd9);
    assign o_onehot  = o_invalid ? ONEHOT_0 : (10'd1 << i_bcd);

endmodule

// File: rtl/dekatron_seq.sv
// Sequencer for a chain of dekatron counting tubes: single-digit steps with
// ripple carry/borrow, settling gaps between steps, and parallel load/clear.
module dekatron_seq
    import dekatron_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int GAP    = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_req,
    input  logic [1:0]            i_op,
    input  logic [4*DIGITS-1:0]   i_data,
    input  logic [10*DIGITS-1:0]  i_dek_out,
    output logic [DIGITS-1:0]     o_dek_enable,
    output logic                  o_dek_reverse,
    output logic                  o_dek_set,
    output logic [10*DIGITS-1:0]  o_dek_in,
    output logic                  o_ready,
    output logic                  o_done,
    output logic                  o_overflow,
    output logic                  o_fault,
    output logic                  o_zero
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNT_W = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [IDX_W-1:0] LAST_DIGIT = IDX_W'(DIGITS - 1);
    localparam logic [CNT_W-1:0] WAIT_INIT  = CNT_W'(GAP - 1);

    state_e               r_state;
    logic [IDX_W-1:0]     r_digit;
    logic [CNT_W-1:0]     r_wait_cnt;
    logic                 r_set_op;
    logic                 r_reverse;
    logic                 r_carry;
    logic                 r_ovf_pend;
    logic                 r_fault_pend;
    logic                 r_ready;
    logic                 r_done;
    logic                 r_overflow;
    logic                 r_fault;
    logic [10*DIGITS-1:0] r_dek_in;

    logic [10*DIGITS-1:0] w_load_onehot;
    logic [DIGITS-1:0]    w_bcd_bad;
    logic [DIGITS-1:0]    w_zero_digit;
    logic [9:0]           w_digit_out [DIGITS];
    logic [9:0]           w_cur;
    logic                 w_cur_ok;
    logic                 w_carry;
    logic                 w_step;

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        bcd2onehot u_bcd2onehot (
            .i_bcd     (i_data[4*gi +: 4]),
            .o_onehot  (w_load_onehot[10*gi +: 10]),
            .o_invalid (w_bcd_bad[gi])
        );
        assign w_digit_out[gi]  = i_dek_out[10*gi +: 10];
        assign w_zero_digit[gi] = (w_digit_out[gi] == ONEHOT_0);
    end

    // Carry/borrow is taken from the pre-step reading while the step is issued.
    assign w_cur    = w_digit_out[r_digit];
    assign w_cur_ok = is_onehot10(w_cur);
    assign w_carry  = r_reverse ? w_cur[0] : w_cur[9];
    assign w_step   = (r_state == ST_STEP);

    assign o_dek_enable  = !w_step  ? '0 :
                           r_set_op ? '1 :
                           w_cur_ok ? (DIGITS'(1) << r_digit) : '0;
    assign o_dek_set     = w_step & r_set_op;
    assign o_dek_reverse = r_reverse;
    assign o_dek_in      = r_dek_in;
    assign o_ready       = r_ready;
    assign o_done        = r_done;
    assign o_overflow    = r_overflow;
    assign o_fault       = r_fault;
    assign o_zero        = &w_zero_digit;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_digit      <= '0;
            r_wait_cnt   <= '0;
            r_set_op     <= 1'b0;
            r_reverse    <= 1'b0;
            r_carry      <= 1'b0;
            r_ovf_pend   <= 1'b0;
            r_fault_pend <= 1'b0;
            r_ready      <= 1'b1;
            r_done       <= 1'b0;
            r_overflow   <= 1'b0;
            r_fault      <= 1'b0;
            r_dek_in     <= '0;
        end else begin
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
            r_fault    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_req) begin
                        r_state      <= ST_STEP;
                        r_ready      <= 1'b0;
                        r_digit      <= '0;
                        r_carry      <= 1'b0;
                        r_ovf_pend   <= 1'b0;
                        r_fault_pend <= 1'b0;
                        r_reverse    <= 1'b0;
                        r_set_op     <= 1'b0;
                        case (op_e'(i_op))
                            OP_DEC:   r_reverse <= 1'b1;
                            OP_LOAD: begin
                                r_set_op     <= 1'b1;
                                r_dek_in     <= w_load_onehot;
                                r_fault_pend <= |w_bcd_bad;
                            end
                            OP_CLEAR: begin
                                r_set_op <= 1'b1;
                                r_dek_in <= {DIGITS{ONEHOT_0}};
                            end
                            default: ;
                        endcase
                    end
                end
                ST_STEP: begin
                    r_wait_cnt <= WAIT_INIT;
                    if (r_set_op) begin
                        r_state <= ST_WAIT;
                    end else if (!w_cur_ok) begin
                        // Corrupt tube reading: abandon the ripple without stepping.
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        r_fault <= 1'b1;
                    end else begin
                        r_state    <= ST_WAIT;
                        r_carry    <= w_carry && (r_digit != LAST_DIGIT);
                        r_ovf_pend <= w_carry && (r_digit == LAST_DIGIT);
                    end
                end
                ST_WAIT: begin
                    if (r_wait_cnt != '0) begin
                        r_wait_cnt <= r_wait_cnt - 1'b1;
                    end else if (r_carry) begin
                        r_state <= ST_STEP;
                        r_digit <= r_digit + 1'b1;
                        r_carry <= 1'b0;
                    end else begin
                        r_state    <= ST_DONE;
                        r_done     <= 1'b1;
                        r_overflow <= r_ovf_pend;
                        r_fault    <= r_fault_pend;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dekatron_seq.sv
// Directed bench for dekatron_seq with a behavioural model of three counting tubes
// on the DekOut/DekEnable interface.
module tb_dekatron_seq;
    import dekatron_pkg::*;

    localparam int DIGITS = 3;
    localparam int GAP    = 2;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        req   = 1'b0;
    logic [1:0]  op    = 2'b00;
    logic [11:0] data  = 12'h000;
    logic [29:0] dek_out;
    logic [2:0]  dek_enable;
    logic        dek_reverse, dek_set;
    logic [29:0] dek_in;
    logic        ready, done, overflow, fault, zero;

    always #5 clk = ~clk;

    dekatron_seq #(.DIGITS(DIGITS), .GAP(GAP)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_req         (req),
        .i_op          (op),
        .i_data        (data),
        .i_dek_out     (dek_out),
        .o_dek_enable  (dek_enable),
        .o_dek_reverse (dek_reverse),
        .o_dek_set     (dek_set),
        .o_dek_in      (dek_in),
        .o_ready       (ready),
        .o_done        (done),
        .o_overflow    (overflow),
        .o_fault       (fault),
        .o_zero        (zero)
    );

    // Tube model: INC moves the glow up one cathode, DEC down, 9<->0 wrapping.
    logic [9:0] tube [DIGITS];
    logic       force0 = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < DIGITS; d++) tube[d] <= 10'd1;
        end else begin
            for (int d = 0; d < DIGITS; d++) begin
                if (dek_enable[d]) begin
                    if (dek_set)          tube[d] <= dek_in[d*10 +: 10];
                    else if (dek_reverse) tube[d] <= {tube[d][0], tube[d][9:1]};
                    else                  tube[d] <= {tube[d][8:0], tube[d][9]};
                end
            end
        end
    end

    always_comb begin
        dek_out = '0;
        for (int d = 0; d < DIGITS; d++) dek_out[d*10 +: 10] = tube[d];
        if (force0) dek_out[9:0] = 10'b00_0000_0011;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [29:0] val3(input int d2, input int d1, input int d0);
        logic [9:0] one;
        one = 10'd1;
        return {one << d2, one << d1, one << d0};
    endfunction

    function automatic logic [29:0] tubes();
        return {tube[2], tube[1], tube[0]};
    endfunction

    int         done_cyc;
    logic       ovf_s, fault_s;
    int         n_steps;
    bit         all_rev, stray;
    logic [2:0] en_hist [0:40];

    task automatic run_op(input logic [1:0] o, input logic [11:0] d, input bit hold);
        @(negedge clk);
        req = 1'b1; op = o; data = d;
        @(posedge clk);
        #1;
        if (!hold) req = 1'b0;
        done_cyc = 0; n_steps = 0; all_rev = 1'b1; stray = 1'b0;
        ovf_s = 1'b0; fault_s = 1'b0;
        for (int i = 0; i <= 40; i++) en_hist[i] = '0;
        for (int c = 1; c <= 40 && done_cyc == 0; c++) begin
            @(negedge clk);
            en_hist[c] = dek_enable;
            if (dek_enable != '0) begin
                n_steps++;
                if (!dek_reverse) all_rev = 1'b0;
            end
            if (!done && (overflow || fault)) stray = 1'b1;
            if (done) begin
                done_cyc = c;
                ovf_s    = overflow;
                fault_s  = fault;
            end
        end
        req = 1'b0;
        if (done_cyc == 0) check("done_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ready", ready, 1);
        check("rst_done", done, 0);
        check("rst_ovf", overflow, 0);
        check("rst_fault", fault, 0);
        check("rst_enable", dek_enable, 0);
        check("rst_set", dek_set, 0);
        check("rst_reverse", dek_reverse, 0);
        check("rst_dekin", dek_in, 0);
        check("rst_zero", zero, 1);
        rst_n = 1'b1;
        @(negedge clk);

        // LOAD 009
        run_op(OP_LOAD, 12'h009, 1'b0);
        check("load009_done_cyc", done_cyc, 4);
        check("load009_en", en_hist[1], 3'b111);
        check("load009_fault", fault_s, 0);
        check("load009_val", tubes(), val3(0, 0, 9));

        // 009 INC -> 010
        run_op(OP_INC, 12'h000, 1'b0);
        check("inc009_done_cyc", done_cyc, 7);
        check("inc009_en1", en_hist[1], 3'b001);
        check("inc009_en4", en_hist[4], 3'b010);
        check("inc009_steps", n_steps, 2);
        check("inc009_ovf", ovf_s, 0);
        check("inc009_val", tubes(), val3(0, 1, 0));
        check("inc009_stray", stray, 0);

        // 999 INC -> 000 with overflow
        run_op(OP_LOAD, 12'h999, 1'b0);
        check("load999_val", tubes(), val3(9, 9, 9));
        check("load999_zero", zero, 0);
        run_op(OP_INC, 12'h000, 1'b0);
        check("inc999_done_cyc", done_cyc, 10);
        check("inc999_en7", en_hist[7], 3'b100);
        check("inc999_steps", n_steps, 3);
        check("inc999_ovf", ovf_s, 1);
        check("inc999_val", tubes(), val3(0, 0, 0));
        check("inc999_zero", zero, 1);
        check("inc999_stray", stray, 0);

        // 000 DEC -> 999 with borrow out
        run_op(OP_DEC, 12'h000, 1'b0);
        check("dec000_done_cyc", done_cyc, 10);
        check("dec000_steps", n_steps, 3);
        check("dec000_rev", all_rev, 1);
        check("dec000_ovf", ovf_s, 1);
        check("dec000_val", tubes(), val3(9, 9, 9));

        // LOAD with an invalid middle digit
        run_op(OP_LOAD, 12'h4A7, 1'b0);
        check("load4a7_done_cyc", done_cyc, 4);
        check("load4a7_fault", fault_s, 1);
        check("load4a7_ovf", ovf_s, 0);
        check("load4a7_val", tubes(), val3(4, 0, 7));

        // CLEAR
        run_op(OP_CLEAR, 12'h123, 1'b0);
        check("clear_done_cyc", done_cyc, 4);
        check("clear_fault", fault_s, 0);
        check("clear_zero", zero, 1);

        // Reset during the WAIT after a digit-0 carry
        run_op(OP_LOAD, 12'h009, 1'b0);
        @(negedge clk);
        req = 1'b1; op = OP_INC;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        check("abort_step_en", dek_enable, 3'b001);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_ready", ready, 1);
        check("abort_done", done, 0);
        check("abort_enable", dek_enable, 0);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int en_seen, done_seen;
            en_seen = 0; done_seen = 0;
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                if (dek_enable != '0) en_seen++;
                if (done) done_seen++;
            end
            check("abort_no_step", en_seen, 0);
            check("abort_no_done", done_seen, 0);
        end
        check("abort_val", tubes(), val3(0, 0, 0));

        // Corrupt digit 0 with Req held through the busy period
        force0 = 1'b1;
        run_op(OP_INC, 12'h000, 1'b1);
        check("fault_done_cyc", done_cyc, 2);
        check("fault_flag", fault_s, 1);
        check("fault_ovf", ovf_s, 0);
        check("fault_no_step", n_steps, 0);
        @(negedge clk);
        check("fault_ready_after", ready, 1);
        check("fault_idle_done", done, 0);
        force0 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
